// File: rtl/lock_if.sv
// Button-pulse and indicator bundle between the input conditioners and the lock sequencer.
// Every input is a single-cycle pulse: it is acted on at the one rising edge where it is high.
// No ready signal exists; a pulse arriving in a state that ignores it is simply dropped.
interface lock_if #(
    parameter int CODE_LEN = 4
) ();
    localparam int DCW = $clog2(CODE_LEN + 1);

    logic [3:0]     key_pulse;
    logic           enter_pulse;
    logic           clear_pulse;
    logic           set_pulse;
    logic           lock_pulse;
    logic           unlocked;
    logic           programming;
    logic           lockout;
    logic           error_pulse;
    logic [DCW-1:0] digit_count;
    logic [1:0]     fail_count;

    modport master (
        output key_pulse, enter_pulse, clear_pulse, set_pulse, lock_pulse,
        input  unlocked, programming, lockout, error_pulse, digit_count, fail_count
    );

    modport slave (
        input  key_pulse, enter_pulse, clear_pulse, set_pulse, lock_pulse,
        output unlocked, programming, lockout, error_pulse, digit_count, fail_count
    );
endinterface

// File: rtl/lock_sequencer.sv
// Combination-lock controller: checks entered digit sequences against a stored code,
// enforces a failed-attempt lockout and allows reprogramming the code while open.
module lock_sequencer #(
    parameter int                      CODE_LEN       = 4,
    parameter logic [2*CODE_LEN-1:0]   DEFAULT_CODE   = 8'h1B,
    parameter int                      MAX_FAILS      = 3,
    parameter int                      LOCKOUT_CYCLES = 1000,
    parameter int                      OPEN_CYCLES    = 500
) (
    input  logic       Clock,
    input  logic       Resetn,
    lock_if.slave      bus,
    output logic [1:0] state_dbg
);
    localparam int DCW  = $clog2(CODE_LEN + 1);
    localparam int MAXC = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        LOCKED  = 2'd0,
        OPEN    = 2'd1,
        PROGRAM = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t                state_q, state_n;
    logic [2*CODE_LEN-1:0] code_q, code_n;
    logic [2*CODE_LEN-1:0] shadow_q, shadow_n;
    logic [DCW-1:0]        dc_q, dc_n;
    logic                  mis_q, mis_n;
    logic                  ovf_q, ovf_n;
    logic [1:0]            fail_q, fail_n;
    logic [TW-1:0]         timer_q, timer_n;
    logic                  err_n;
    logic                  unlocked_q, programming_q, lockout_q, err_q;

    logic       key_any, key_one, any_pulse, entry_full;
    logic [1:0] key_digit, code_digit;

    always_comb begin
        key_any   = |bus.key_pulse;
        key_one   = $onehot(bus.key_pulse);
        any_pulse = key_any | bus.enter_pulse | bus.clear_pulse | bus.set_pulse | bus.lock_pulse;
        entry_full = (dc_q == DCW'(CODE_LEN));
        if (bus.key_pulse[3])      key_digit = 2'd3;
        else if (bus.key_pulse[2]) key_digit = 2'd2;
        else if (bus.key_pulse[1]) key_digit = 2'd1;
        else                       key_digit = 2'd0;
        code_digit = 2'd0;
        for (int i = 0; i < CODE_LEN; i++)
            if (dc_q == DCW'(i)) code_digit = code_q[2*i +: 2];
    end

    always_comb begin
        state_n  = state_q;
        code_n   = code_q;
        shadow_n = shadow_q;
        dc_n     = dc_q;
        mis_n    = mis_q;
        ovf_n    = ovf_q;
        fail_n   = fail_q;
        timer_n  = timer_q;
        err_n    = 1'b0;
        case (state_q)
            LOCKED: begin
                timer_n = '0;
                if (bus.clear_pulse) begin
                    dc_n = '0; mis_n = 1'b0; ovf_n = 1'b0;
                end else if (bus.enter_pulse) begin
                    dc_n = '0; mis_n = 1'b0; ovf_n = 1'b0;
                    if (entry_full && !mis_q && !ovf_q) begin
                        state_n = OPEN;
                        fail_n  = '0;
                    end else begin
                        err_n  = 1'b1;
                        fail_n = (fail_q == 2'(MAX_FAILS)) ? fail_q : fail_q + 2'd1;
                        if (fail_n == 2'(MAX_FAILS)) state_n = LOCKOUT;
                    end
                end else if (key_any) begin
                    if (!entry_full) begin
                        if (!key_one || key_digit != code_digit) mis_n = 1'b1;
                        dc_n = dc_q + DCW'(1);
                    end else begin
                        ovf_n = 1'b1;
                    end
                end
            end
            OPEN: begin
                timer_n = any_pulse ? '0 : timer_q + TW'(1);
                if (bus.lock_pulse) begin
                    state_n = LOCKED;
                end else if (bus.set_pulse) begin
                    state_n = PROGRAM;
                    dc_n = '0; mis_n = 1'b0; ovf_n = 1'b0;
                end else if (!any_pulse && timer_q == TW'(OPEN_CYCLES - 1)) begin
                    state_n = LOCKED;
                end
            end
            PROGRAM: begin
                // mis/ovf double as the reject flag while capturing a new code
                timer_n = any_pulse ? '0 : timer_q + TW'(1);
                if (bus.clear_pulse) begin
                    dc_n = '0; mis_n = 1'b0; ovf_n = 1'b0;
                end else if (bus.enter_pulse) begin
                    if (entry_full && !mis_q && !ovf_q) code_n = shadow_q;
                    else                                err_n  = 1'b1;
                    state_n = OPEN;
                    timer_n = '0;
                    dc_n = '0; mis_n = 1'b0; ovf_n = 1'b0;
                end else if (bus.lock_pulse) begin
                    state_n = LOCKED;
                    dc_n = '0; mis_n = 1'b0; ovf_n = 1'b0;
                end else if (key_any) begin
                    if (!entry_full) begin
                        if (!key_one) mis_n = 1'b1;
                        for (int i = 0; i < CODE_LEN; i++)
                            if (dc_q == DCW'(i)) shadow_n[2*i +: 2] = key_digit;
                        dc_n = dc_q + DCW'(1);
                    end else begin
                        ovf_n = 1'b1;
                    end
                end else if (timer_q == TW'(OPEN_CYCLES - 1)) begin
                    state_n = LOCKED;
                    dc_n = '0; mis_n = 1'b0; ovf_n = 1'b0;
                end
            end
            LOCKOUT: begin
                timer_n = timer_q + TW'(1);
                if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
                    state_n = LOCKED;
                    fail_n  = '0;
                    timer_n = '0;
                end
            end
            default: state_n = LOCKED;
        endcase
        if (state_n == OPEN && state_q != OPEN) timer_n = '0;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q       <= LOCKED;
            code_q        <= DEFAULT_CODE;
            shadow_q      <= '0;
            dc_q          <= '0;
            mis_q         <= 1'b0;
            ovf_q         <= 1'b0;
            fail_q        <= '0;
            timer_q       <= '0;
            unlocked_q    <= 1'b0;
            programming_q <= 1'b0;
            lockout_q     <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_n;
            code_q        <= code_n;
            shadow_q      <= shadow_n;
            dc_q          <= dc_n;
            mis_q         <= mis_n;
            ovf_q         <= ovf_n;
            fail_q        <= fail_n;
            timer_q       <= timer_n;
            unlocked_q    <= (state_n == OPEN) || (state_n == PROGRAM);
            programming_q <= (state_n == PROGRAM);
            lockout_q     <= (state_n == LOCKOUT);
            err_q         <= err_n;
        end
    end

    assign bus.unlocked    = unlocked_q;
    assign bus.programming = programming_q;
    assign bus.lockout     = lockout_q;
    assign bus.error_pulse = err_q;
    assign bus.digit_count = dc_q;
    assign bus.fail_count  = fail_q;
    assign state_dbg       = state_q;
endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer: unlock, lockout, overflow, reprogramming,
// idle timeout, asynchronous reset and same-cycle pulse priority.
module tb_lock_sequencer;
    localparam int CODE_LEN       = 4;
    localparam int MAX_FAILS      = 3;
    localparam int LOCKOUT_CYCLES = 20;
    localparam int OPEN_CYCLES    = 30;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic [1:0] state_dbg;

    lock_if #(.CODE_LEN(CODE_LEN)) bus ();

    lock_sequencer #(
        .CODE_LEN(CODE_LEN),
        .DEFAULT_CODE(8'h1B),
        .MAX_FAILS(MAX_FAILS),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
        .OPEN_CYCLES(OPEN_CYCLES)
    ) dut (
        .Clock(Clock),
        .Resetn(Resetn),
        .bus(bus),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    // scoreboard
    int         n_cmp = 0;
    int         n_err = 0;
    logic [5:0] exp_q[$];
    time        t0, t1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // status = {unlocked, programming, lockout, error_pulse, fail_count}
    task automatic expect_st(input string tag, input logic [5:0] exp);
        logic [5:0] got;
        got = {bus.unlocked, bus.programming, bus.lockout, bus.error_pulse, bus.fail_count};
        exp_q.push_back(exp);
        chk(tag, {26'd0, got}, {26'd0, exp_q.pop_front()});
    endtask

    // drivers
    task automatic pulse(input logic [3:0] k, input logic e, input logic c,
                         input logic s, input logic l);
        @(negedge Clock);
        bus.key_pulse = k; bus.enter_pulse = e; bus.clear_pulse = c;
        bus.set_pulse = s; bus.lock_pulse = l;
        @(negedge Clock);
        bus.key_pulse = '0; bus.enter_pulse = 1'b0; bus.clear_pulse = 1'b0;
        bus.set_pulse = 1'b0; bus.lock_pulse = 1'b0;
    endtask

    task automatic press_key(input logic [1:0] d);
        pulse(4'b0001 << d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_enter();
        pulse(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_clear();
        pulse(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic press_set();
        pulse(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic press_lock();
        pulse(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // first digit in seq[1:0]
    task automatic enter_digits(input logic [15:0] seq, input int n);
        for (int i = 0; i < n; i++) press_key(seq[2*i +: 2]);
    endtask

    initial begin
        bus.key_pulse = '0; bus.enter_pulse = 1'b0; bus.clear_pulse = 1'b0;
        bus.set_pulse = 1'b0; bus.lock_pulse = 1'b0;
        Resetn = 1'b0;
        repeat (3) @(negedge Clock);
        expect_st("reset_status", 6'b000000);
        chk("reset_dc", {29'd0, bus.digit_count}, 0);
        chk("reset_state", {30'd0, state_dbg}, 0);
        Resetn = 1'b1;

        // default code 3,2,1,0
        enter_digits(16'h001B, 4);
        chk("t1_dc4", {29'd0, bus.digit_count}, 4);
        expect_st("t1_locked_pre_enter", 6'b000000);
        press_enter();
        expect_st("t1_open", 6'b100000);
        chk("t1_dc_cleared", {29'd0, bus.digit_count}, 0);
        press_lock();
        expect_st("t1_relock", 6'b000000);

        // three failures with 3,2,1,1 -> lockout
        for (int k = 1; k <= 3; k++) begin
            enter_digits(16'h005B, 4);
            press_enter();
            t0 = $time;
            expect_st($sformatf("t2_fail%0d", k), {2'b00, (k == 3), 1'b1, 2'(k)});
        end
        @(negedge Clock);
        expect_st("t2_err_one_cycle", 6'b001011);
        enter_digits(16'h001B, 4);
        chk("t2_digits_ignored", {29'd0, bus.digit_count}, 0);
        press_enter();
        expect_st("t2_enter_ignored", 6'b001011);
        for (int i = 0; i < 100 && bus.lockout; i++) @(negedge Clock);
        t1 = $time;
        chk("t2_lockout_len", 32'((t1 - t0) / 10), LOCKOUT_CYCLES);
        expect_st("t2_released", 6'b000000);

        // overflow, then clear and correct entry
        enter_digits(16'h001B, 4);
        press_key(2'd0);
        chk("t3_dc_saturates", {29'd0, bus.digit_count}, 4);
        press_enter();
        expect_st("t3_overflow_fail", 6'b000101);
        enter_digits(16'h001B, 2);
        chk("t3_dc2", {29'd0, bus.digit_count}, 2);
        press_clear();
        chk("t3_clear_dc", {29'd0, bus.digit_count}, 0);
        expect_st("t3_clear_keeps_fail", 6'b000001);
        enter_digits(16'h001B, 4);
        press_enter();
        expect_st("t3_open", 6'b100000);

        // reprogram to 0,1,2,3
        press_set();
        expect_st("t4_program", 6'b110000);
        chk("t4_state", {30'd0, state_dbg}, 2);
        enter_digits(16'h00E4, 4);
        press_enter();
        expect_st("t4_programmed", 6'b100000);
        press_lock();
        expect_st("t4_locked", 6'b000000);
        enter_digits(16'h001B, 4);
        press_enter();
        expect_st("t4_old_code_fails", 6'b000101);
        enter_digits(16'h00E4, 4);
        press_enter();
        expect_st("t4_new_code_opens", 6'b100000);

        // rejected program: multi-bit key then three digits
        press_set();
        pulse(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
        enter_digits(16'h0039, 3);
        chk("t5_dc4", {29'd0, bus.digit_count}, 4);
        press_enter();
        expect_st("t5_reject", 6'b100100);
        press_lock();
        enter_digits(16'h00E4, 4);
        press_enter();
        t0 = $time;
        expect_st("t5_code_kept", 6'b100000);
        for (int i = 0; i < 100 && bus.unlocked; i++) @(negedge Clock);
        t1 = $time;
        chk("t5_open_len", 32'((t1 - t0) / 10), OPEN_CYCLES);
        expect_st("t5_timeout", 6'b000000);

        // asynchronous reset mid-entry with programmed code held
        press_enter();
        expect_st("t6_empty_enter_fail", 6'b000101);
        enter_digits(16'h00E4, 2);
        chk("t6_dc2", {29'd0, bus.digit_count}, 2);
        @(negedge Clock);
        #2 Resetn = 1'b0;
        #1;
        expect_st("t6_async_reset", 6'b000000);
        chk("t6_reset_dc", {29'd0, bus.digit_count}, 0);
        @(negedge Clock);
        Resetn = 1'b1;
        enter_digits(16'h00E4, 4);
        press_enter();
        expect_st("t6_programmed_gone", 6'b000101);
        enter_digits(16'h001B, 4);
        press_enter();
        expect_st("t6_default_back", 6'b100000);
        press_lock();

        // same-cycle priority
        enter_digits(16'h001B, 4);
        pulse(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_st("t7_clear_beats_enter", 6'b000000);
        chk("t7_clear_dc", {29'd0, bus.digit_count}, 0);
        press_enter();
        expect_st("t7_empty_enter", 6'b000101);
        pulse(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_st("t7_enter_beats_digit", 6'b000110);
        chk("t7_digit_dropped", {29'd0, bus.digit_count}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Central controller of the combination lock.
- Consumes the one-cycle pulses produced by the per-button input conditioners: digit keys, enter, clear, set and lock.
- Checks entered digit sequences against a stored code and drives the unlocked/lockout indicators.
- Enforces a failed-attempt lockout and supports reprogramming the code while open.

Parameters:
- CODE_LEN, 4, number of digits in the combination (2..8).
- DEFAULT_CODE, 8'h1B, reset code, 2 bits per digit; first-entered digit in bits [1:0]. Default sequence is 3,2,1,0.
- MAX_FAILS, 3, consecutive failed attempts that trigger lockout.
- LOCKOUT_CYCLES, 1000, clock cycles spent in LOCKOUT.
- OPEN_CYCLES, 500, idle cycles in OPEN/PROGRAM before automatic relock.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- key_pulse  in  4  one-hot digit pulses; bit i = digit i; one cycle wide.
- enter_pulse  in  1  submit entry.
- clear_pulse  in  1  discard current entry.
- set_pulse  in  1  enter programming mode (OPEN only).
- lock_pulse  in  1  relock (OPEN only).
- unlocked  out  1  high in OPEN and PROGRAM.
- programming  out  1  high in PROGRAM.
- lockout  out  1  high in LOCKOUT.
- error_pulse  out  1  one-cycle pulse on each failed attempt or rejected program.
- digit_count  out  $clog2(CODE_LEN+1)  digits entered so far, saturating at CODE_LEN.
- fail_count  out  2  consecutive failures.

Behaviour:
- All outputs are registered. Reset (Resetn=0, asynchronous):
  - state=LOCKED, code=DEFAULT_CODE;
  - digit_count, fail_count, timers, mismatch and overflow flags = 0;
  - all outputs 0. Reset mid-operation discards any programmed code.
- States:
  - LOCKED: awaiting entry.
  - OPEN: unlocked.
  - PROGRAM: capturing a new code.
  - LOCKOUT: all inputs ignored.
- Same-cycle priority: clear > enter > digit. Lower-priority pulses in that cycle are ignored.
- Digit handling (LOCKED):
  - A key_pulse with exactly one bit set is a valid digit d.
  - If digit_count<CODE_LEN, compare d to code digit [2*digit_count+1:2*digit_count]; on inequality set mismatch.
  - digit_count increments, saturating at CODE_LEN; a digit arriving when digit_count==CODE_LEN sets overflow.
  - A key_pulse with more than one bit set counts as a digit and sets mismatch.
- Enter (LOCKED):
  - Success when digit_count==CODE_LEN, mismatch=0 and overflow=0. Next state is OPEN; unlocked rises on the edge after the enter cycle (1-cycle latency); fail_count clears.
  - Otherwise: error_pulse for one cycle, fail_count+1. If the new fail_count==MAX_FAILS, go to LOCKOUT; otherwise stay LOCKED.
  - Entry (digit_count, mismatch, overflow) is cleared after every enter.
  - Enter with digit_count==0 also counts as a failure.
- Clear: resets the entry only. No failure is counted and fail_count is unchanged.
- LOCKOUT:
  - Counts LOCKOUT_CYCLES cycles, then goes to LOCKED with fail_count=0.
  - All pulses ignored, including set and lock.
- OPEN:
  - lock_pulse: go to LOCKED.
  - set_pulse: go to PROGRAM with entry cleared.
  - Digit and enter pulses are ignored.
  - Idle timer: reloads on any input pulse. After OPEN_CYCLES cycles without a pulse, go to LOCKED.
- PROGRAM:
  - Valid digits are written into a shadow register at position digit_count.
  - Invalid (multi-bit) digits and overflow set a reject flag.
  - Enter with digit_count==CODE_LEN and no reject: shadow is copied to code, go to OPEN.
  - Enter otherwise: error_pulse, code unchanged, go to OPEN. fail_count is not affected.
  - clear_pulse restarts the capture; lock_pulse discards the capture and goes to LOCKED.
  - The idle timeout also applies: on expiry, discard the capture and go to LOCKED.
- fail_count never exceeds MAX_FAILS. Timers are wide enough for the larger of LOCKOUT_CYCLES and OPEN_CYCLES.

Test Plan:
- Reset, then digits 3,2,1,0 and enter -> unlocked=1 one cycle after enter, fail_count=0, digit_count=0.
- Digits 3,2,1,1 and enter, three times (MAX_FAILS=3, LOCKOUT_CYCLES=20) -> three error_pulses, fail_count=1,2,3. lockout=1 for 20 cycles, with digits 3,2,1,0 and enter ignored throughout. Then LOCKED with fail_count=0.
- Digits 3,2,1,0,0 (overflow) and enter -> error_pulse, stays locked. Digits 3,2 then clear, then 3,2,1,0 and enter -> unlocked, fail_count=0.
- While OPEN: set_pulse, digits 0,1,2,3, enter -> unlocked=1, programming=0. After lock_pulse, old code 3,2,1,0 fails and new code 0,1,2,3 unlocks.
- While PROGRAM: key_pulse=4'b0011 then three digits, enter -> error_pulse, code unchanged. Separately, OPEN_CYCLES=30 with no inputs while OPEN -> unlocked drops after 30 cycles.
- Resetn asserted mid-entry and while holding a programmed code -> all outputs 0 immediately; code reverts so that 3,2,1,0 unlocks. Same-cycle clear+enter -> treated as clear, no error_pulse.
